nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle WIDTH-bit add/subtract unit that time-shares one 4-bit carry-lookahead slice (`cla_4bit`), processing one nibble per clock from LSB to MSB. A registered carry links successive nibbles. It sits beside the ALU as a low-area arithmetic path with a start/done handshake for a sequencing master.

## Interface
- `WIDTH`, 32: operand/result width in bits.
  - Must be a multiple of 4 and ≥ 8.
  - Nibble count N = WIDTH/4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new operation; sampled only when `ready`=1.
- `op_sub`  in  1  0 = a+b, 1 = a−b; sampled with `start`.
- `a`  in  WIDTH  operand A; sampled with `start`.
- `b`  in  WIDTH  operand B; sampled with `start`.
- `ready`  out  1  unit accepts `start` this cycle.
- `busy`  out  1  nibble iterations in progress.
- `done`  out  1  one-cycle pulse when `result`, `cout` and `overflow` are valid.
- `result`  out  WIDTH  sum/difference.
  - Held stable from `done` until the next accepted `start`.
- `cout`  out  1  final carry out.
  - For subtract: 1 = no borrow.
- `overflow`  out  1  signed overflow (see Configuration).

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - `ready`=1, `busy`=0.
  - `start`=1 moves to RUN, and on that edge:
    - latch A into shift register `sa`;
    - latch B into `sb`, inverted when `op_sub`=1;
    - set carry register to `op_sub`;
    - clear nibble counter;
    - latch `op_sub`.
- RUN:
  - `busy`=1, `ready`=0.
  - Each cycle the slice adds `sa[3:0]`, `sb[3:0]` and the carry register.
  - On the clock edge:
    - the 4-bit sum shifts into `result` from the top (right shift by 4);
    - `sa` and `sb` shift right by 4;
    - carry register takes the slice carry-out;
    - counter increments.
  - After the edge where counter = N−1, go to DONE.
- DONE (exactly one cycle):
  - `done`=1, `ready`=1, `busy`=0.
  - `cout` equals the carry register.
  - `start`=1 here is accepted exactly as in IDLE and moves directly to RUN.
  - Otherwise go to IDLE.
- `start` while in RUN is ignored; no queuing and no error.
- Nothing is published to `result` or `cout` before `done`:
  - `result` is updated only through the shift path;
  - `result` is cleared on accept;
  - `cout` updates only on entry to DONE.
- The counter is ⌈log2 N⌉ bits and never wraps past N−1.

## Timing
- Reset (async assert, any state):
  - state IDLE;
  - `ready`=1, `busy`=0, `done`=0;
  - `result`=0, `cout`=0, `overflow`=0;
  - internal registers cleared.
- Reset assertion mid-RUN aborts the operation; no `done` is produced.
- Deassertion is synchronous to `clk` via the team's standard reset synchronizer upstream.
- Latency:
  - `start` accepted at edge T;
  - RUN occupies edges T+1 … T+N;
  - `done` is high in the cycle following edge T+N.
  - For WIDTH=32: `done` appears 9 cycles after the start cycle.
- Throughput: one operation per N+1 cycles with back-to-back `start` in DONE.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `NSA_OVERFLOW_EN` defined:
  - on entry to DONE, `overflow` = (MSB of A == MSB of inverted-or-not B) AND (`result[WIDTH-1]` != MSB of A);
  - the needed MSBs are captured when nibble N−1 is processed;
  - `overflow` is cleared on accept.
- `NSA_OVERFLOW_EN` undefined:
  - `overflow` tied to 0;
  - the MSB capture logic is not generated.

## Test plan
- WIDTH=32, add 0xFFFFFFFF + 0x00000001 → at `done` (9 cycles after start): `result`=0x00000000, `cout`=1, `overflow`=0.
- Subtract 0x00000005 − 0x00000007 → `result`=0xFFFFFFFE, `cout`=0 (borrow); 0x7 − 0x5 → `result`=0x2, `cout`=1.
- Add 0x7FFFFFFF + 0x00000001 → `result`=0x80000000, `overflow`=1 with `NSA_OVERFLOW_EN`, `overflow`=0 without it; 0x80000000 − 1 → `result`=0x7FFFFFFF, `overflow`=1 (macro on).
- Pulse `start` with new operands during RUN cycles 3 and 5 → ignored; the original operation completes with its own result, and exactly one `done` pulse.
- Assert `rst_n`=0 at RUN cycle 4 → all outputs immediately at reset values; no `done` after release; next `start` computes 0x12345678 + 0x11111111 = 0x23456789 correctly.
- Hold `start`=1 continuously with changing operands → `done` every 9 cycles; each result matches the operands sampled in the preceding DONE cycle.

Source files
------------

// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: start/done handshake bundle for the nibble-serial adder.
// Ports: start, op_sub, a, b (master to slave); ready, busy, done, result, cout, overflow (slave to master).
interface nibble_serial_adder_if #(parameter int WIDTH = 32);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    modport master (output start, op_sub, a, b, input ready, busy, done, result, cout, overflow);
    modport slave  (input start, op_sub, a, b, output ready, busy, done, result, cout, overflow);
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle add/subtract reusing one 4-bit carry-lookahead slice, LSB nibble first.
// Ports: clk, rst_n (async active-low), bus (nibble_serial_adder_if.slave).
// Optional: define NSA_OVERFLOW_EN to compute signed overflow; otherwise overflow is tied to 0.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g, p;
    logic [3:1] c;
    assign g = a & b;
    assign p = a ^ b;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);
    assign s    = p ^ {c, ci};
endmodule

module nibble_serial_adder #(parameter int WIDTH = 32) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int N  = WIDTH / 4;
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb, res;
    logic             c, cout_r, co, accept, last;
    logic [CW-1:0]    cnt;
    logic [3:0]       sum;
    cla_4bit u_cla (.a(sa[3:0]), .b(sb[3:0]), .ci(c), .s(sum), .co(co));
    assign accept = bus.start && state != RUN;
    assign last   = state == RUN && cnt == CW'(N - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    // Outputs decode only the state register, so no input reaches an output combinationally.
    always_comb begin
        state_nx  = state == RUN ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
        bus.ready = state != RUN;
        bus.busy  = state == RUN;
        bus.done  = state == DONE;
    end
    // Subtraction is a + ~b + 1: the inversion is applied once at capture and the +1 seeds the carry.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            c      <= 1'b0;
            cout_r <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            sa  <= bus.a;
            sb  <= bus.op_sub ? ~bus.b : bus.b;
            c   <= bus.op_sub;
            res <= '0;
            cnt <= '0;
        end else if (state == RUN) begin
            res <= {sum, res[WIDTH-1:4]};
            sa  <= sa >> 4;
            sb  <= sb >> 4;
            c   <= co;
            cnt <= last ? cnt : cnt + 1'b1;
            if (last) cout_r <= co;
        end
    assign bus.result = res;
    assign bus.cout   = cout_r;
`ifdef NSA_OVERFLOW_EN
    logic ovf;
    // On the last nibble sa[3]/sb[3] are the operand MSBs and sum[3] is the result MSB.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)      ovf <= 1'b0;
        else if (accept) ovf <= 1'b0;
        else if (last)   ovf <= (sa[3] == sb[3]) && (sum[3] != sa[3]);
    assign bus.overflow = ovf;
`else
    assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed self-checking bench for nibble_serial_adder (WIDTH=32).
module tb_nibble_serial_adder;
`ifdef NSA_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    nibble_serial_adder_if #(.WIDTH(32)) bus ();
    nibble_serial_adder #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic test_reset;
        checks++; if (bus.ready !== 1'b1)     begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
        checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.result !== 32'h0)   begin errors++; $display("FAIL reset_result: got %h expected 0", bus.result); end
        checks++; if (bus.cout !== 1'b0)      begin errors++; $display("FAIL reset_cout: got %b expected 0", bus.cout); end
        checks++; if (bus.overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    endtask

    // Drives one operation from IDLE and checks latency, busy, results and hold after done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [31:0] er, input logic ec, input logic eo, input string name);
        int cyc = 0;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.op_sub = sub; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.a = ~a; bus.b = ~b; bus.op_sub = ~sub;
        cyc = 1;
        checks++; if (bus.busy !== 1'b1 || bus.ready !== 1'b0)
            begin errors++; $display("FAIL %s_busy: got busy=%b ready=%b expected busy=1 ready=0", name, bus.busy, bus.ready); end
        while (bus.done !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        checks++; if (cyc !== 9) begin errors++; $display("FAIL %s_latency: got %0d expected 9", name, cyc); end
        checks++; if (bus.result !== er) begin errors++; $display("FAIL %s_result: got %h expected %h", name, bus.result, er); end
        checks++; if (bus.cout !== ec) begin errors++; $display("FAIL %s_cout: got %b expected %b", name, bus.cout, ec); end
        checks++; if (bus.overflow !== eo) begin errors++; $display("FAIL %s_overflow: got %b expected %b", name, bus.overflow, eo); end
        repeat (2) @(negedge clk);
        checks++; if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.result !== er)
            begin errors++; $display("FAIL %s_hold: got done=%b ready=%b result=%h expected done=0 ready=1 result=%h", name, bus.done, bus.ready, bus.result, er); end
    endtask

    task automatic test_add;
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, "add_wrap");
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, OVF_EN, "add_ovf");
        run_op(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, "add_plain");
    endtask

    task automatic test_sub;
        run_op(32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, "sub_borrow");
        run_op(32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0, "sub_pos");
        run_op(32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, OVF_EN, "sub_ovf");
    endtask

    task automatic test_ignore_start;
        int dones = 0;
        @(negedge clk);
        bus.a = 32'h11111111; bus.b = 32'h22222222; bus.op_sub = 1'b0; bus.start = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            bus.start = (i == 3 || i == 5);
            bus.a = 32'hDEAD0000 + i; bus.b = 32'h0BAD0000; bus.op_sub = i[0];
            if (bus.done === 1'b1) begin
                dones++;
                checks++; if (bus.result !== 32'h33333333)
                    begin errors++; $display("FAIL ignore_result: got %h expected 33333333", bus.result); end
                checks++; if (i !== 9) begin errors++; $display("FAIL ignore_latency: got %0d expected 9", i); end
            end
        end
        bus.start = 1'b0;
        checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", dones); end
    endtask

    task automatic test_reset_mid_run;
        int dones = 0;
        @(negedge clk);
        bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF; bus.op_sub = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", dones); end
        run_op(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back;
        logic [31:0] oa [3] = '{32'h00000001, 32'h0000000A, 32'hFFFF0000};
        logic [31:0] ob [3] = '{32'h00000002, 32'h00000003, 32'h00010000};
        logic        os [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] er [3] = '{32'h00000003, 32'h00000007, 32'h00000000};
        logic        ec [3] = '{1'b0, 1'b1, 1'b1};
        int idx = 0;
        int cyc = 0;
        @(negedge clk);
        bus.a = oa[0]; bus.b = ob[0]; bus.op_sub = os[0]; bus.start = 1'b1;
        for (int t = 0; t < 60 && idx < 3; t++) begin
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) begin
                checks++; if (bus.result !== er[idx] || bus.cout !== ec[idx])
                    begin errors++; $display("FAIL b2b_%0d: got result=%h cout=%b expected result=%h cout=%b", idx, bus.result, bus.cout, er[idx], ec[idx]); end
                checks++; if (cyc !== 9) begin errors++; $display("FAIL b2b_period_%0d: got %0d expected 9", idx, cyc); end
                cyc = 0;
                idx++;
                if (idx < 3) begin bus.a = oa[idx]; bus.b = ob[idx]; bus.op_sub = os[idx]; end
                else bus.start = 1'b0;
            end else begin
                bus.a = $urandom; bus.b = $urandom; bus.op_sub = 1'($urandom_range(1));
            end
        end
        bus.start = 1'b0;
        checks++; if (idx !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", idx); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0; bus.op_sub = 1'b0; bus.a = '0; bus.b = '0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_add();
        test_sub();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
